// File: rtl/cswap_multiword_add_ctrl.sv
// ---------------------------------------------------------------------------
// cswap_multiword_add_ctrl
//
// Adds two WORDS x WIDTH-bit operands by streaming one WIDTH-bit slice per
// cycle through an external combinational cswap_wide_adder. The carry-out of
// each slice is fed back as the carry-in of the next slice. Word 0 is the
// least significant slice and is processed first.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   start             request a new addition (sampled only in IDLE)
//   op_a, op_b, cin   operands and carry into word 0 (latched on accept)
//   busy              high while RUN or DONE
//   done              one-cycle pulse, result/cout valid
//   result, cout      registered sum and final carry, held until next accept
//   add_a, add_b,
//   add_cin           slice operands and carry driven to the adder (0 unless RUN)
//   add_sum, add_cout adder results, consumed during RUN
// ---------------------------------------------------------------------------
module cswap_multiword_add_ctrl #(
    parameter int WIDTH = 4,
    parameter int WORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [WIDTH*WORDS-1:0] op_a,
    input  logic [WIDTH*WORDS-1:0] op_b,
    input  logic                   cin,
    output logic                   busy,
    output logic                   done,
    output logic [WIDTH*WORDS-1:0] result,
    output logic                   cout,
    output logic [WIDTH-1:0]       add_a,
    output logic [WIDTH-1:0]       add_b,
    output logic                   add_cin,
    input  logic [WIDTH-1:0]       add_sum,
    input  logic                   add_cout
);

    localparam int TOT_W = WIDTH * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [IDX_W-1:0]   idx_r;
    logic [IDX_W-1:0]   idx_next_s;
    logic               last_s;
    logic [TOT_W-1:0]   a_r;
    logic [TOT_W-1:0]   b_r;
    logic               carry_r;
    logic [TOT_W-1:0]   result_r;
    logic               cout_r;
    logic               busy_r;
    logic               done_r;
    logic [WIDTH-1:0]   add_a_r;
    logic [WIDTH-1:0]   add_b_r;
    logic               add_cin_r;

    // Select word idx of a packed multi-word vector.
    function automatic logic [WIDTH-1:0] word_sel(input logic [TOT_W-1:0] vec,
                                                  input logic [IDX_W-1:0] idx);
        logic [WIDTH-1:0] sel;
        sel = {WIDTH{1'b0}};
        for (int w = 0; w < WORDS; w++) begin
            if (idx == IDX_W'(w)) begin
                sel = vec[w*WIDTH +: WIDTH];
            end
        end
        return sel;
    endfunction

    assign last_s     = (idx_r == IDX_W'(WORDS - 1));
    assign idx_next_s = idx_r + {{(IDX_W-1){1'b0}}, 1'b1};

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Status flags are registered decodes of the next state so they line up
    // exactly with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_s != ST_IDLE);
            done_r <= (state_s == ST_DONE);
        end
    end

    // Operand latching, slice sequencing and result accumulation. The adder
    // drive registers are preloaded one edge ahead with the slice that the
    // coming RUN cycle needs, so they are valid for the whole cycle and are
    // zero in every non-RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r       <= {TOT_W{1'b0}};
            b_r       <= {TOT_W{1'b0}};
            carry_r   <= 1'b0;
            idx_r     <= {IDX_W{1'b0}};
            result_r  <= {TOT_W{1'b0}};
            cout_r    <= 1'b0;
            add_a_r   <= {WIDTH{1'b0}};
            add_b_r   <= {WIDTH{1'b0}};
            add_cin_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        a_r       <= op_a;
                        b_r       <= op_b;
                        carry_r   <= cin;
                        idx_r     <= {IDX_W{1'b0}};
                        result_r  <= {TOT_W{1'b0}};
                        cout_r    <= 1'b0;
                        add_a_r   <= op_a[WIDTH-1:0];
                        add_b_r   <= op_b[WIDTH-1:0];
                        add_cin_r <= cin;
                    end
                end
                ST_RUN: begin
                    for (int w = 0; w < WORDS; w++) begin
                        if (idx_r == IDX_W'(w)) begin
                            result_r[w*WIDTH +: WIDTH] <= add_sum;
                        end
                    end
                    carry_r <= add_cout;
                    if (last_s) begin
                        cout_r    <= add_cout;
                        add_a_r   <= {WIDTH{1'b0}};
                        add_b_r   <= {WIDTH{1'b0}};
                        add_cin_r <= 1'b0;
                    end else begin
                        idx_r     <= idx_next_s;
                        add_a_r   <= word_sel(a_r, idx_next_s);
                        add_b_r   <= word_sel(b_r, idx_next_s);
                        add_cin_r <= add_cout;
                    end
                end
                ST_DONE: begin
                    add_a_r   <= {WIDTH{1'b0}};
                    add_b_r   <= {WIDTH{1'b0}};
                    add_cin_r <= 1'b0;
                end
                default: begin
                    add_a_r   <= {WIDTH{1'b0}};
                    add_b_r   <= {WIDTH{1'b0}};
                    add_cin_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign result  = result_r;
    assign cout    = cout_r;
    assign add_a   = add_a_r;
    assign add_b   = add_b_r;
    assign add_cin = add_cin_r;

endmodule

// File: tb/tb_cswap_multiword_add_ctrl.sv
// ---------------------------------------------------------------------------
// Self-checking bench for cswap_multiword_add_ctrl (WIDTH=4, WORDS=4).
// The attached combinational slice adder is modelled inline on the add_*
// ports. Directed vectors with hand-computed results and per-cycle carries.
// ---------------------------------------------------------------------------
module tb_cswap_multiword_add_ctrl;

    localparam int WIDTH = 4;
    localparam int WORDS = 4;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        cin;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        cout;
    logic [3:0]  add_a;
    logic [3:0]  add_b;
    logic        add_cin;
    logic [3:0]  add_sum;
    logic        add_cout;

    int n_cmp;
    int n_err;

    cswap_multiword_add_ctrl #(
        .WIDTH (WIDTH),
        .WORDS (WORDS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op_a     (op_a),
        .op_b     (op_b),
        .cin      (cin),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout)
    );

    // Slice adder model.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0000, add_cin};

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one addition from IDLE; caller is 1 time unit after an edge.
    task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic c, input logic [15:0] exp_res, input logic exp_cout,
                          input logic [3:0] exp_cins, input logic disturb);
        op_a  = a;
        op_b  = b;
        cin   = c;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < WORDS; i++) begin
            chk({name, "_busy_run"}, 32'(busy), 32'd1);
            chk({name, "_done_run"}, 32'(done), 32'd0);
            chk({name, "_add_cin"}, 32'(add_cin), 32'(exp_cins[i]));
            chk({name, "_add_a"}, 32'(add_a), 32'(a[i*4 +: 4]));
            chk({name, "_add_b"}, 32'(add_b), 32'(b[i*4 +: 4]));
            if (disturb && i == 1) begin
                op_a  = 16'hFFFF;
                cin   = 1'b1;
                start = 1'b1;
            end
            if (disturb && i == 2) begin
                start = 1'b0;
            end
            step();
        end
        chk({name, "_done"}, 32'(done), 32'd1);
        chk({name, "_busy_done"}, 32'(busy), 32'd1);
        chk({name, "_result"}, 32'(result), 32'(exp_res));
        chk({name, "_cout"}, 32'(cout), 32'(exp_cout));
        chk({name, "_add_idle"}, 32'({add_a, add_b, add_cin}), 32'd0);
        step();
        chk({name, "_done_after"}, 32'(done), 32'd0);
        chk({name, "_busy_after"}, 32'(busy), 32'd0);
        chk({name, "_result_hold"}, 32'(result), 32'(exp_res));
        chk({name, "_cout_hold"}, 32'(cout), 32'(exp_cout));
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        start = 1'b0;
        op_a  = 16'h0000;
        op_b  = 16'h0000;
        cin   = 1'b0;
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_add", 32'({add_a, add_b, add_cin}), 32'd0);
        rst_n = 1'b1;
        step();

        // Idle with start low.
        for (int i = 0; i < 10; i++) begin
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_done", 32'(done), 32'd0);
            chk("idle_add", 32'({add_a, add_b, add_cin}), 32'd0);
            step();
        end

        run_op("t1", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 4'b0000, 1'b0);
        run_op("t2", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 4'b0110, 1'b0);
        run_op("t3", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 4'b1111, 1'b0);
        run_op("t4", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 4'b0000, 1'b1);
        // Start issued in the IDLE cycle right after DONE.
        run_op("t4b", 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 4'b0000, 1'b0);

        // Reset in the second RUN cycle.
        op_a  = 16'hFFFF;
        op_b  = 16'h0001;
        cin   = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("t5_busy_pre", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_busy_rst", 32'(busy), 32'd0);
        chk("t5_done_rst", 32'(done), 32'd0);
        chk("t5_result_rst", 32'(result), 32'd0);
        chk("t5_cout_rst", 32'(cout), 32'd0);
        chk("t5_add_rst", 32'({add_a, add_b, add_cin}), 32'd0);
        step();
        #4;
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 6; i++) begin
            chk("t5_no_done", 32'(done), 32'd0);
            chk("t5_no_busy", 32'(busy), 32'd0);
            step();
        end
        run_op("t5", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 4'b1110, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
